// File: rtl/lsu_pkg.sv
// Shared LSU definitions: access sizes, controller states, opcode constants
// and the small helpers used when an op is accepted.
package lsu_pkg;

    localparam int LSU_XLEN = 32;

    // Major opcodes, shared with lsu_decode.
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        LSU_BYTE = 2'd0,
        LSU_HALF = 2'd1,
        LSU_WORD = 2'd2
    } lsu_size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_WB   = 2'd3
    } lsu_state_e;

    // Size encoding 3 is reserved and behaves as a word access.
    function automatic lsu_size_e norm_size(input logic [1:0] size);
        case (size)
            2'd0:    return LSU_BYTE;
            2'd1:    return LSU_HALF;
            default: return LSU_WORD;
        endcase
    endfunction

    // Halves need an even address, words need a word-aligned address.
    function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] lane);
        case (size)
            LSU_HALF: return lane[0];
            LSU_WORD: return (lane != 2'b00);
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load-data aligner: shifts the addressed lane down to bit 0 and
// sign- or zero-extends byte and half results.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [LSU_XLEN-1:0] rdata,
    input  logic [1:0]          lane,
    input  lsu_size_e           size,
    input  logic                zero_ext,
    output logic [LSU_XLEN-1:0] wb_data
);

    logic [LSU_XLEN-1:0] sh;
    logic                ext_bit;

    assign sh = rdata >> {lane, 3'b000};

    // Select and extend the addressed byte/half; words pass through.
    always_comb begin
        // NOTE: default assignments first so every path drives every output and no latch is inferred.
        wb_data = sh;
        ext_bit = 1'b0;
        case (size)
            LSU_BYTE: begin
                ext_bit = ~zero_ext & sh[7];
                wb_data = {{24{ext_bit}}, sh[7:0]};
            end
            LSU_HALF: begin
                ext_bit = ~zero_ext & sh[15];
                wb_data = {{16{ext_bit}}, sh[15:0]};
            end
            default: wb_data = sh;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// LSU memory controller: executes one decoded load/store at a time against a
// word-wide memory port, then returns aligned load data to writeback.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic            op_is_load,
    input  logic            op_zero_ext,
    input  logic            op_is_nop,
    input  logic [1:0]      op_size,
    input  logic [XLEN-1:0] op_base,
    input  logic [XLEN-1:0] op_store_data,
    input  logic [4:0]      op_rd,
    input  logic [11:0]     op_imm,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic            mem_req_we,
    output logic [XLEN-1:0] mem_req_addr,
    output logic [XLEN-1:0] mem_req_wdata,
    output logic [3:0]      mem_req_be,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            err
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    lsu_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       lane_q;
    lsu_size_e        size_q;
    logic             zext_q;
    logic [4:0]       rd_q;

    logic [XLEN-1:0]  ea;
    lsu_size_e        acc_size;
    logic [1:0]       acc_lane;
    logic             acc_misalign;
    logic [3:0]       acc_be;
    logic [XLEN-1:0]  acc_wdata;
    logic [XLEN-1:0]  align_data;

    // Effective address wraps modulo 2^XLEN.
    assign ea           = op_base + {{(XLEN-12){op_imm[11]}}, op_imm};
    assign acc_size     = norm_size(op_size);
    assign acc_lane     = ea[1:0];
    assign acc_misalign = is_misaligned(acc_size, acc_lane);

    // Store byte enables and lane-replicated write data for the presented op.
    always_comb begin
        acc_be    = 4'hF;
        acc_wdata = op_store_data;
        case (acc_size)
            LSU_BYTE: begin
                acc_be    = 4'b0001 << acc_lane;
                acc_wdata = {4{op_store_data[7:0]}};
            end
            LSU_HALF: begin
                acc_be    = 4'b0011 << acc_lane;
                acc_wdata = {2{op_store_data[15:0]}};
            end
            default: begin
                acc_be    = 4'hF;
                acc_wdata = op_store_data;
            end
        endcase
    end

    lsu_load_align u_align (
        .rdata    (mem_resp_rdata),
        .lane     (lane_q),
        .size     (size_q),
        .zero_ext (zext_q),
        .wb_data  (align_data)
    );

    // Controller FSM with registered outputs and the response timeout counter.
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            lane_q        <= 2'b00;
            size_q        <= LSU_WORD;
            zext_q        <= 1'b0;
            rd_q          <= 5'd0;
            op_ready      <= 1'b1;
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_be    <= 4'h0;
            wb_valid      <= 1'b0;
            wb_rd         <= 5'd0;
            wb_data       <= '0;
            err           <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            err      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (op_valid && op_ready && !op_is_nop) begin
                        if (acc_misalign) begin
                            // Rejected without touching memory; stay ready.
                            err <= 1'b1;
                        end else begin
                            lane_q        <= acc_lane;
                            size_q        <= acc_size;
                            zext_q        <= op_zero_ext;
                            rd_q          <= op_rd;
                            mem_req_valid <= 1'b1;
                            mem_req_we    <= ~op_is_load;
                            mem_req_addr  <= {ea[XLEN-1:2], 2'b00};
                            mem_req_be    <= op_is_load ? 4'hF : acc_be;
                            mem_req_wdata <= op_is_load ? '0 : acc_wdata;
                            op_ready      <= 1'b0;
                            state         <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        if (mem_req_we) begin
                            // Writes are fire-and-forget.
                            op_ready <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            cnt   <= '0;
                            state <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (mem_resp_valid) begin
                        wb_data  <= align_data;
                        wb_rd    <= rd_q;
                        wb_valid <= (rd_q != 5'd0);
                        state    <= S_WB;
                    end else if (cnt == CNT_LAST) begin
                        err      <= 1'b1;
                        op_ready <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WB: begin
                    op_ready <= 1'b1;
                    state    <= S_IDLE;
                end
                default: begin
                    op_ready <= 1'b1;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed testbench for lsu_mem_ctrl.
module tb_lsu_mem_ctrl;

    localparam int TIMEOUT_CYC = 256;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic        op_is_load;
    logic        op_zero_ext;
    logic        op_is_nop;
    logic [1:0]  op_size;
    logic [31:0] op_base;
    logic [31:0] op_store_data;
    logic [4:0]  op_rd;
    logic [11:0] op_imm;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_be;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err;

    int checks = 0;
    int errors = 0;

    lsu_mem_ctrl #(.XLEN(32), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk            (clk),
        .rst            (rst),
        .op_valid       (op_valid),
        .op_ready       (op_ready),
        .op_is_load     (op_is_load),
        .op_zero_ext    (op_zero_ext),
        .op_is_nop      (op_is_nop),
        .op_size        (op_size),
        .op_base        (op_base),
        .op_store_data  (op_store_data),
        .op_rd          (op_rd),
        .op_imm         (op_imm),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_we     (mem_req_we),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_be     (mem_req_be),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    // Advance one clock; outputs are sampled and inputs driven 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op for exactly one accept edge.
    task automatic issue(input logic ld, input logic zx, input logic nop, input logic [1:0] sz,
                         input logic [31:0] base, input logic [31:0] sd, input logic [4:0] rd,
                         input logic [11:0] imm);
        op_valid      = 1'b1;
        op_is_load    = ld;
        op_zero_ext   = zx;
        op_is_nop     = nop;
        op_size       = sz;
        op_base       = base;
        op_store_data = sd;
        op_rd         = rd;
        op_imm        = imm;
        tick();
        op_valid  = 1'b0;
        op_is_nop = 1'b0;
    endtask

    // Run a load: ready held low ready_delay cycles, response resp_delay cycles into S_RESP.
    task automatic run_load(input logic zx, input logic [1:0] sz, input logic [31:0] base,
                            input logic [11:0] imm, input logic [4:0] rd, input logic [31:0] rdata,
                            input int ready_delay, input int resp_delay,
                            output logic [31:0] got_addr, output int unstable, output int wb_count,
                            output logic [31:0] got_data, output logic [4:0] got_rd,
                            output int ready_idx);
        mem_req_ready = (ready_delay == 0);
        issue(1'b1, zx, 1'b0, sz, base, 32'h0, rd, imm);
        got_addr  = mem_req_addr;
        unstable  = 0;
        wb_count  = 0;
        got_data  = 32'h0;
        got_rd    = 5'd0;
        ready_idx = -1;
        for (int i = 0; i <= ready_delay; i++) begin
            if (mem_req_valid !== 1'b1 || mem_req_addr !== got_addr ||
                mem_req_be !== 4'hF || mem_req_we !== 1'b0)
                unstable++;
            if (i == ready_delay) mem_req_ready = 1'b1;
            tick();
        end
        for (int i = 0; i < resp_delay; i++) begin
            if (wb_valid !== 1'b0 || mem_req_valid !== 1'b0) unstable++;
            tick();
        end
        mem_resp_valid = 1'b1;
        mem_resp_rdata = rdata;
        tick();
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            if (wb_valid === 1'b1) begin
                wb_count++;
                got_data = wb_data;
                got_rd   = wb_rd;
            end
            if (op_ready === 1'b1 && ready_idx < 0) ready_idx = i;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({op_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be,
             wb_valid, wb_rd, wb_data, err} !== {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
             1'b0, 5'd0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs ready=%b req=%b addr=%h be=%h wb=%b err=%b",
                     op_ready, mem_req_valid, mem_req_addr, mem_req_be, wb_valid, err);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_store();
        mem_req_ready = 1'b1;
        // SB base 0x1000 + 3, data 0xAB
        issue(1'b0, 1'b0, 1'b0, 2'd0, 32'h1000, 32'h0000_00AB, 5'd0, 12'd3);
        checks++;
        if ({mem_req_valid, mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata, op_ready} !==
            {1'b1, 1'b1, 32'h1000, 4'b1000, 32'hABAB_ABAB, 1'b0}) begin
            errors++;
            $display("FAIL sb_req valid=%b we=%b addr=%h be=%b wdata=%h exp 1 1 00001000 1000 abababab",
                     mem_req_valid, mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata);
        end
        tick();
        checks++;
        if ({op_ready, mem_req_valid, wb_valid, err} !== 4'b1000) begin
            errors++;
            $display("FAIL sb_done ready=%b req=%b wb=%b err=%b exp 1 0 0 0",
                     op_ready, mem_req_valid, wb_valid, err);
        end
        // SH base 0x100 + 2, data 0x1234ABCD: upper half lanes
        issue(1'b0, 1'b0, 1'b0, 2'd1, 32'h100, 32'h1234_ABCD, 5'd0, 12'd2);
        checks++;
        if ({mem_req_addr, mem_req_be, mem_req_wdata} !== {32'h100, 4'b1100, 32'hABCD_ABCD}) begin
            errors++;
            $display("FAIL sh_req addr=%h be=%b wdata=%h exp 00000100 1100 abcdabcd",
                     mem_req_addr, mem_req_be, mem_req_wdata);
        end
        tick();
        // SW with size 3 behaves as word
        issue(1'b0, 1'b0, 1'b0, 2'd3, 32'h200, 32'hCAFE_F00D, 5'd0, 12'd4);
        checks++;
        if ({mem_req_addr, mem_req_be, mem_req_wdata} !== {32'h204, 4'hF, 32'hCAFE_F00D}) begin
            errors++;
            $display("FAIL sw_req addr=%h be=%b wdata=%h exp 00000204 1111 cafef00d",
                     mem_req_addr, mem_req_be, mem_req_wdata);
        end
        tick();
    endtask

    task automatic test_load_half();
        logic [31:0] a, d;
        logic [4:0]  r;
        int          u, n, ri;
        run_load(1'b0, 2'd1, 32'h2000, 12'd2, 5'd5, 32'h8001_1234, 0, 0, a, u, n, d, r, ri);
        checks++;
        if (a !== 32'h2000 || n !== 1 || d !== 32'hFFFF_8001 || r !== 5'd5 || ri !== 1) begin
            errors++;
            $display("FAIL lh addr=%h wbs=%0d data=%h rd=%0d ready_idx=%0d exp 00002000 1 ffff8001 5 1",
                     a, n, d, r, ri);
        end
        run_load(1'b1, 2'd1, 32'h2000, 12'd2, 5'd5, 32'h8001_1234, 0, 0, a, u, n, d, r, ri);
        checks++;
        if (n !== 1 || d !== 32'h0000_8001) begin
            errors++;
            $display("FAIL lhu wbs=%0d data=%h exp 1 00008001", n, d);
        end
        // LB lane 1, sign-extended: byte 0x80
        run_load(1'b0, 2'd0, 32'h3000, 12'd1, 5'd7, 32'h1122_8033, 0, 0, a, u, n, d, r, ri);
        checks++;
        if (n !== 1 || d !== 32'hFFFF_FF80 || r !== 5'd7) begin
            errors++;
            $display("FAIL lb wbs=%0d data=%h rd=%0d exp 1 ffffff80 7", n, d, r);
        end
    endtask

    task automatic test_load_word_align();
        logic [31:0] a, d;
        logic [4:0]  r;
        int          u, n, ri;
        run_load(1'b0, 2'd2, 32'h10, 12'hFFC, 5'd3, 32'h1357_9BDF, 0, 0, a, u, n, d, r, ri);
        checks++;
        if (a !== 32'h0C || n !== 1 || d !== 32'h1357_9BDF) begin
            errors++;
            $display("FAIL lw_neg_imm addr=%h wbs=%0d data=%h exp 0000000c 1 13579bdf", a, n, d);
        end
        // LW at ea 0x0E is misaligned
        issue(1'b1, 1'b0, 1'b0, 2'd2, 32'h10, 32'h0, 5'd3, 12'hFFE);
        checks++;
        if ({err, mem_req_valid, op_ready} !== 3'b101) begin
            errors++;
            $display("FAIL lw_misalign err=%b req=%b ready=%b exp 1 0 1", err, mem_req_valid, op_ready);
        end
        // Back-to-back misaligned half then NOP
        issue(1'b1, 1'b0, 1'b0, 2'd1, 32'h201, 32'h0, 5'd3, 12'd0);
        checks++;
        if ({err, mem_req_valid, op_ready} !== 3'b101) begin
            errors++;
            $display("FAIL lh_misalign err=%b req=%b ready=%b exp 1 0 1", err, mem_req_valid, op_ready);
        end
        issue(1'b0, 1'b0, 1'b1, 2'd2, 32'h0, 32'h0, 5'd0, 12'd0);
        checks++;
        if ({err, mem_req_valid, op_ready, wb_valid} !== 4'b0010) begin
            errors++;
            $display("FAIL nop err=%b req=%b ready=%b wb=%b exp 0 0 1 0",
                     err, mem_req_valid, op_ready, wb_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, d;
        logic [4:0]  r;
        int          u, n, ri;
        run_load(1'b0, 2'd2, 32'h4000, 12'd8, 5'd9, 32'hA5A5_0F0F, 3, 5, a, u, n, d, r, ri);
        checks++;
        if (a !== 32'h4008 || u !== 0 || n !== 1 || d !== 32'hA5A5_0F0F || r !== 5'd9) begin
            errors++;
            $display("FAIL backpressure addr=%h unstable=%0d wbs=%0d data=%h rd=%0d exp 00004008 0 1 a5a50f0f 9",
                     a, u, n, d, r);
        end
    endtask

    task automatic test_timeout();
        int n;
        mem_req_ready = 1'b1;
        issue(1'b1, 1'b0, 1'b0, 2'd2, 32'h40, 32'h0, 5'd4, 12'd0);
        n = 1;
        while (err !== 1'b1 && n < TIMEOUT_CYC + 40) begin
            tick();
            n++;
        end
        checks++;
        if (n !== TIMEOUT_CYC + 2 || op_ready !== 1'b1 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout err_cycle=%0d ready=%b wb=%b exp %0d 1 0",
                     n, op_ready, wb_valid, TIMEOUT_CYC + 2);
        end
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h1234_5678;
        tick();
        mem_resp_valid = 1'b0;
        tick();
        checks++;
        if ({wb_valid, err, op_ready} !== 3'b001) begin
            errors++;
            $display("FAIL late_resp wb=%b err=%b ready=%b exp 0 0 1", wb_valid, err, op_ready);
        end
    endtask

    task automatic test_reset_mid_op();
        logic seen_wb;
        logic [31:0] a, d;
        logic [4:0]  r;
        int          u, n, ri;
        mem_req_ready = 1'b1;
        issue(1'b1, 1'b0, 1'b0, 2'd2, 32'h80, 32'h0, 5'd6, 12'd0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({op_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_be,
             wb_valid, wb_rd, wb_data, err} !== {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
             1'b0, 5'd0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_in_resp ready=%b req=%b addr=%h wb=%b rd=%0d data=%h err=%b",
                     op_ready, mem_req_valid, mem_req_addr, wb_valid, wb_rd, wb_data, err);
        end
        seen_wb = 1'b0;
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (wb_valid === 1'b1 || err === 1'b1) seen_wb = 1'b1;
            tick();
        end
        checks++;
        if (seen_wb !== 1'b0) begin
            errors++;
            $display("FAIL reset_abandon wb_or_err=%b exp 0", seen_wb);
        end
        // Reset with a request pending against a stalled memory
        mem_req_ready = 1'b0;
        issue(1'b0, 1'b0, 1'b0, 2'd2, 32'h90, 32'h1, 5'd0, 12'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_req_ready = 1'b1;
        checks++;
        if ({mem_req_valid, op_ready} !== 2'b01) begin
            errors++;
            $display("FAIL reset_in_req req=%b ready=%b exp 0 1", mem_req_valid, op_ready);
        end
        // LB to x0: passes through writeback without a pulse
        run_load(1'b0, 2'd0, 32'h500, 12'd0, 5'd0, 32'h0000_00FF, 0, 0, a, u, n, d, r, ri);
        checks++;
        if (n !== 0 || ri !== 1) begin
            errors++;
            $display("FAIL lb_rd0 wbs=%0d ready_idx=%0d exp 0 1", n, ri);
        end
    endtask

    initial begin
        rst            = 1'b1;
        op_valid       = 1'b0;
        op_is_load     = 1'b0;
        op_zero_ext    = 1'b0;
        op_is_nop      = 1'b0;
        op_size        = 2'd0;
        op_base        = 32'h0;
        op_store_data  = 32'h0;
        op_rd          = 5'd0;
        op_imm         = 12'd0;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 32'h0;

        test_reset();
        test_store();
        test_load_half();
        test_load_word_align();
        test_backpressure();
        test_timeout();
        test_reset_mid_op();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
